// File: rtl/fnn_eval_pkg.sv
// Shared parameter defaults and FSM state encodings for the FNN evaluation sequencer.
package fnn_eval_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 16;
    localparam int unsigned SAMPLE_LEN_DEF     = 784;
    localparam int unsigned NUM_SAMPLES_DEF    = 20;
    localparam int unsigned OUT_WIDTH_DEF      = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 65535;
    localparam int unsigned ADDR_WIDTH_DEF     = $clog2(NUM_SAMPLES_DEF * (SAMPLE_LEN_DEF + 1));

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRIME  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_LABEL  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

endpackage

// File: rtl/fnn_eval_sequencer_if.sv
// Bus bundle between the sequencer, the sample store and the network under test.
interface fnn_eval_sequencer_if
    import fnn_eval_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] IN;
    logic                  in_data_valid;
    logic                  out_valid;
    logic [OUT_WIDTH-1:0]  OUT;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output IN,
        output in_data_valid,
        input  out_valid,
        input  OUT
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  IN,
        input  in_data_valid,
        output out_valid,
        output OUT
    );

endinterface

// File: rtl/fnn_timeout_ctr.sv
// WAIT-state watchdog: cleared by load, counts enabled cycles, flags the last allowed cycle.
module fnn_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Asserted during the TIMEOUT_CYCLES-th enabled cycle so the caller leaves on that edge.
    assign expired_c = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fnn_eval_sequencer.sv
// Streams stored samples into the network, waits for its answer and scores it against the label.
module fnn_eval_sequencer
    import fnn_eval_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned SAMPLE_LEN     = SAMPLE_LEN_DEF,
    parameter int unsigned NUM_SAMPLES    = NUM_SAMPLES_DEF,
    parameter int unsigned OUT_WIDTH      = OUT_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    fnn_eval_sequencer_if.master               bus,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   sample_cnt,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   correct_cnt,
    output logic [$clog2(NUM_SAMPLES+1)-1:0]   timeout_cnt,
    output logic                               last_pass,
    output logic [OUT_WIDTH-1:0]               last_result
);

    localparam int unsigned CNT_W  = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned ADDR_W = $clog2(NUM_SAMPLES * (SAMPLE_LEN + 1));
    localparam int unsigned WORD_W = $clog2(SAMPLE_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(NUM_SAMPLES);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(SAMPLE_LEN);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(SAMPLE_LEN + 1);

    logic [2:0]            state;
    logic [2:0]            state_d;
    logic [ADDR_W-1:0]     base;
    logic [WORD_W-1:0]     word_cnt;
    logic [DATA_WIDTH-1:0] label;
    logic                  ov_q;
    logic                  timed_out;
    logic                  expired_c;
    logic                  ov_rise_c;
    logic                  last_sample_c;
    logic                  pass_c;
    logic                  streaming_c;
    logic [ADDR_W-1:0]     fetch_addr_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign ov_rise_c     = bus.out_valid & ~ov_q;
    assign last_sample_c = (32'(sample_cnt) + 32'd1) >= NUM_SAMPLES;
    assign pass_c        = ~timed_out && (last_result == OUT_WIDTH'(label));
    assign streaming_c   = (state == S_STREAM) && (word_cnt != WORD_LAST);
    // Address runs one word ahead of the captured data and parks on the label word.
    assign fetch_addr_c  = ((32'(word_cnt) + 32'd2) > SAMPLE_LEN)
                         ? base + ADDR_W'(SAMPLE_LEN)
                         : base + ADDR_W'(word_cnt) + ADDR_W'(2);

    fnn_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .load      (state == S_LABEL),
        .enable    (state == S_WAIT),
        .expired_c (expired_c)
    );

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_d = S_PRIME;
            S_PRIME:        state_d = S_STREAM;
            S_STREAM:       if (word_cnt == WORD_LAST) state_d = S_LABEL;
            S_LABEL:        state_d = S_WAIT;
            S_WAIT:         if (ov_rise_c || expired_c) state_d = S_CHECK;
            S_CHECK:        state_d = last_sample_c ? S_DONE : S_PRIME;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.mem_addr      <= '0;
            bus.IN            <= '0;
            bus.in_data_valid <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            sample_cnt        <= '0;
            correct_cnt       <= '0;
            timeout_cnt       <= '0;
            last_pass         <= 1'b0;
            last_result       <= '0;
            base              <= '0;
            word_cnt          <= '0;
            label             <= '0;
            ov_q              <= 1'b0;
            timed_out         <= 1'b0;
        end else begin
            ov_q              <= bus.out_valid;
            busy              <= (state_d != S_IDLE) && (state_d != S_DONE);
            done              <= (state_d == S_DONE);
            bus.in_data_valid <= streaming_c;
            if (streaming_c) bus.IN <= bus.mem_rdata;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sample_cnt   <= '0;
                        correct_cnt  <= '0;
                        timeout_cnt  <= '0;
                        last_pass    <= 1'b0;
                        last_result  <= '0;
                        timed_out    <= 1'b0;
                        base         <= '0;
                        word_cnt     <= '0;
                        bus.mem_addr <= '0;
                    end
                end
                S_PRIME: begin
                    word_cnt     <= '0;
                    bus.mem_addr <= base + ADDR_W'(1);
                end
                S_STREAM: begin
                    if (word_cnt != WORD_LAST) word_cnt <= word_cnt + WORD_W'(1);
                    bus.mem_addr <= fetch_addr_c;
                end
                S_LABEL: label <= bus.mem_rdata;
                S_WAIT: begin
                    // A same-cycle answer beats the timeout.
                    if (ov_rise_c) begin
                        last_result <= bus.OUT;
                        timed_out   <= 1'b0;
                    end else if (expired_c) begin
                        timed_out   <= 1'b1;
                        timeout_cnt <= sat_inc(timeout_cnt);
                    end
                end
                S_CHECK: begin
                    last_pass    <= pass_c;
                    sample_cnt   <= sat_inc(sample_cnt);
                    if (pass_c) correct_cnt <= sat_inc(correct_cnt);
                    base         <= base + STRIDE;
                    bus.mem_addr <= base + STRIDE;
                    word_cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fnn_eval_sequencer.sv
// Directed bench: 3 samples of 4 words + label 7, network answers driven per sample.
module tb_fnn_eval_sequencer;
    import fnn_eval_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned L  = 4;
    localparam int unsigned NS = 3;
    localparam int unsigned OW = 32;
    localparam int unsigned TO = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 2;

    localparam int M_ANS    = 0;
    localparam int M_SILENT = 1;
    localparam int M_HELD   = 2;
    localparam int M_PULSE  = 3;
    localparam int M_START  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] sample_cnt;
    logic [CW-1:0] correct_cnt;
    logic [CW-1:0] timeout_cnt;
    logic          last_pass;
    logic [OW-1:0] last_result;
    logic [DW-1:0] mem [0:15];

    int n_checks = 0;
    int n_fail   = 0;

    fnn_eval_sequencer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .ADDR_WIDTH(AW)) bus ();

    fnn_eval_sequencer #(
        .DATA_WIDTH     (DW),
        .SAMPLE_LEN     (L),
        .NUM_SAMPLES    (NS),
        .OUT_WIDTH      (OW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .sample_cnt  (sample_cnt),
        .correct_cnt (correct_cnt),
        .timeout_cnt (timeout_cnt),
        .last_pass   (last_pass),
        .last_result (last_result)
    );

    always #5 clk = ~clk;

    // Sample store with one-cycle read latency.
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_run();
        int g;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("start_busy", 32'(busy), 32'd1);
        check_val("start_done", 32'(done), 32'd0);
        check_val("start_sample_clr", 32'(sample_cnt), 32'd0);
        check_val("start_correct_clr", 32'(correct_cnt), 32'd0);
        check_val("start_timeout_clr", 32'(timeout_cnt), 32'd0);
        check_val("start_pass_clr", 32'(last_pass), 32'd0);
        check_val("start_result_clr", last_result, 32'd0);
        check_val("start_addr", 32'(bus.mem_addr), 32'd0);
        g = 0;
        while (!bus.in_data_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check_val("first_word_latency", 32'(g), 32'd2);
    endtask

    task automatic serve_sample(input int s, input int mode, input logic [31:0] ans);
        int g;
        int words;
        int prev_to;
        g = 0;
        words = 0;
        while (!bus.in_data_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        check_val("burst_seen", 32'(bus.in_data_valid), 32'd1);
        if (mode == M_HELD) begin
            bus.out_valid = 1'b1;
            bus.OUT = 32'd9;
        end
        while (bus.in_data_valid && words < 8) begin
            check_val("in_word", 32'(bus.IN), 32'(words + 1));
            words++;
            if (mode == M_PULSE) begin
                bus.out_valid = (words == 2);
                bus.OUT = 32'd9;
            end
            @(negedge clk);
        end
        check_val("burst_len", 32'(words), 32'(L));

        prev_to = int'(timeout_cnt);
        case (mode)
            M_SILENT: begin
                g = 0;
                while (int'(timeout_cnt) == prev_to && g < 40) begin
                    @(negedge clk);
                    g++;
                end
                check_val("timeout_cycles", 32'(g), 32'd17);
            end
            M_HELD: begin
                repeat (5) @(negedge clk);
                check_val("held_no_verdict", 32'(sample_cnt), 32'(s));
                bus.out_valid = 1'b0;
                @(negedge clk);
                bus.out_valid = 1'b1;
                bus.OUT = ans;
                @(negedge clk);
                bus.out_valid = 1'b0;
            end
            M_START: begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check_val("start_in_wait_cnt", 32'(sample_cnt), 32'(s));
                check_val("start_in_wait_busy", 32'(busy), 32'd1);
                @(negedge clk);
                bus.out_valid = 1'b1;
                bus.OUT = ans;
                @(negedge clk);
                bus.out_valid = 1'b0;
            end
            default: begin
                repeat (3) @(negedge clk);
                bus.out_valid = 1'b1;
                bus.OUT = ans;
                @(negedge clk);
                bus.out_valid = 1'b0;
            end
        endcase

        g = 0;
        while (int'(sample_cnt) != s + 1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        check_val("sample_done", 32'(sample_cnt), 32'(s + 1));
        check_val("last_pass", 32'(last_pass), (mode != M_SILENT && ans == 32'd7) ? 32'd1 : 32'd0);
        if (mode != M_SILENT) check_val("last_result", last_result, ans);
    endtask

    task automatic run3(input int m0, input int m1, input int m2,
                        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                        input int exp_correct, input int exp_to);
        start_run();
        serve_sample(0, m0, a0);
        serve_sample(1, m1, a1);
        serve_sample(2, m2, a2);
        check_val("run_done", 32'(done), 32'd1);
        check_val("run_busy", 32'(busy), 32'd0);
        check_val("run_samples", 32'(sample_cnt), 32'(NS));
        check_val("run_correct", 32'(correct_cnt), 32'(exp_correct));
        check_val("run_timeouts", 32'(timeout_cnt), 32'(exp_to));
        check_val("run_valid_low", 32'(bus.in_data_valid), 32'd0);
    endtask

    initial begin
        int g;
        for (int s = 0; s < 3; s++) begin
            for (int w = 0; w < 4; w++) mem[s * 5 + w] = 16'(w + 1);
            mem[s * 5 + 4] = 16'd7;
        end
        mem[15] = 16'd0;
        reset = 1'b0;
        start = 1'b0;
        bus.out_valid = 1'b0;
        bus.OUT = '0;

        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_samples", 32'(sample_cnt), 32'd0);
        check_val("rst_correct", 32'(correct_cnt), 32'd0);
        check_val("rst_timeouts", 32'(timeout_cnt), 32'd0);
        check_val("rst_pass", 32'(last_pass), 32'd0);
        check_val("rst_result", last_result, 32'd0);
        check_val("rst_valid", 32'(bus.in_data_valid), 32'd0);
        check_val("rst_addr", 32'(bus.mem_addr), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // All correct, with a start pulse ignored during WAIT of sample 1.
        run3(M_ANS, M_START, M_ANS, 32'd7, 32'd7, 32'd7, 3, 0);
        // Started from DONE; sample 1 answers wrong.
        run3(M_ANS, M_ANS, M_ANS, 32'd7, 32'd5, 32'd7, 2, 0);
        // Sample 2 never answers.
        run3(M_ANS, M_ANS, M_SILENT, 32'd7, 32'd7, 32'd0, 2, 1);
        // out_valid high before WAIT must not produce a verdict.
        run3(M_HELD, M_PULSE, M_ANS, 32'd7, 32'd7, 32'd7, 3, 0);

        // Reset on the second STREAM cycle of sample 1.
        start_run();
        serve_sample(0, M_ANS, 32'd7);
        g = 0;
        while (!bus.in_data_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        reset = 1'b0;
        @(negedge clk);
        check_val("mid_rst_valid", 32'(bus.in_data_valid), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_samples", 32'(sample_cnt), 32'd0);
        check_val("mid_rst_correct", 32'(correct_cnt), 32'd0);
        check_val("mid_rst_pass", 32'(last_pass), 32'd0);
        check_val("mid_rst_result", last_result, 32'd0);
        check_val("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        reset = 1'b1;
        run3(M_ANS, M_ANS, M_ANS, 32'd7, 32'd7, 32'd7, 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
